fb_scan_arbiter: RTL and testbench
==================================

Name: fb_scan_arbiter

Overview:
- Owns the single-port frame-buffer SRAM and shares it between two users: VGA scanout (pixel reads) and the GPU draw path (single-pixel writes).
- Presents the VGA driver's framebuffer interface: a rising edge on next-pixel advances to the next pixel, and a level reset rewinds to pixel 0.
- Prefetches packed 4-pixel words into a small FIFO, so scanout never waits on draw traffic.
- Sits between the VGA driver, the rasteriser write port and the SRAM macro.

Parameters:
- ADDR_WIDTH, 14, SRAM word-address width.
- FRAME_WORDS, 4800, words per frame (4 pixels/word; 160x120 default). Must be ≤ 2^ADDR_WIDTH.
- FIFO_DEPTH, 4, prefetch FIFO depth in words, power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- scan_next_pixel_in  in  1  advance to next pixel on rising edge
- scan_reset_in  in  1  level; rewind scanout to pixel 0 (driven by v_sync)
- scan_pixel_out  out  4  current pixel
- scan_underrun_out  out  1  sticky: advance requested with empty FIFO
- wr_valid_in  in  1  draw write request
- wr_ready_out  out  1  draw write accepted when valid&&ready
- wr_addr_in  in  ADDR_WIDTH+2  pixel address
- wr_pixel_in  in  4  pixel value
- mem_en_out  out  1  SRAM access strobe
- mem_we_out  out  1  1=write, 0=read
- mem_addr_out  out  ADDR_WIDTH  word address
- mem_wmask_out  out  4  nibble write mask
- mem_wdata_out  out  16  write data
- mem_rdata_in  in  16  read data, valid the cycle after a read strobe

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset: scan_pixel_out=0, scan_underrun_out=0, wr_ready_out=0, and mem_en/we/addr/wmask/wdata=0. FIFO is emptied, the read pointer and nibble index are 0, and in-flight reads are discarded. An rst asserted mid-write aborts that write; the memory outputs are 0 on the next cycle.
- Packing: pixel 4k+i lives in word k, bits [4i+3:4i].
- Memory outputs are registered. A grant decided in cycle N appears on mem_* in N+1, and read data is captured in N+2.
- Each cycle, the arbiter grants in this priority order:
  1. Scanout read, if scan_reset_in=0 and fifo_count+inflight < FIFO_DEPTH. Address = read pointer, which then increments and wraps FRAME_WORDS-1 -> 0.
  2. Otherwise a draw write, if wr_valid_in=1.
- wr_ready_out is combinational: high exactly when state=RUN, not in rst, and no read is granted this cycle.
- Write issue: word = wr_addr_in>>2, mask = onehot(wr_addr_in[1:0]), wdata = {4{wr_pixel_in}}. A write with word ≥ FRAME_WORDS is accepted but dropped (no mem strobe).
- Scanout output: scan_pixel_out = the head word's nibble at the nibble index, or 0 if the FIFO is empty.
- Edge detect uses a registered copy of scan_next_pixel_in. On a rising edge:
  - Nibble index increments.
  - Going from 3 -> 0 pops the head word.
  - Edge with empty FIFO: scan_underrun_out := 1 (sticky until rst), no other change.
  - Pop and capture in the same cycle: count unchanged.
- scan_reset_in=1, every cycle:
  - FIFO flushed, read pointer=0, nibble=0.
  - In-flight read returns discarded (tracked by a discard counter).
  - Rising edges ignored; edge-detect register still updates.
  - No reads issued; writes get the full port.
- On release, prefetch starts from word 0. Pixel 0 is valid on scan_pixel_out no later than 4 cycles after release.
- Writes to words already in the FIFO do not update prefetched data; they are visible from the next frame.
- FSM states:
  - RUN: normal arbitration.
  - CLEAR: exists only with the optional feature.

Optional Feature:
- Macro: FB_CLEAR_EN.
- With the macro, three ports are added: clear_req_in (1), clear_value_in (4) and clear_busy_out (1).
- RUN -> CLEAR is taken on clear_req_in=1. clear_value_in is latched and clear_busy_out=1.
- In CLEAR, the write slot sweeps words 0..FRAME_WORDS-1 with mask 1111 and data {4{value}}. Scanout reads keep priority, and wr_ready_out=0.
- After the last word, the FSM returns to RUN and clear_busy_out=0 on the following cycle. clear_req_in is ignored while busy.
- rst aborts the clear.
- Without the macro, the ports and the CLEAR state are absent.

Test Plan:
- Prefetch/order: preload word0=0x3210, word1=0x7654; pulse scan_reset_in 10 cycles, then release -> scan_pixel_out=0 within 4 cycles; 7 rising edges 4 cycles apart -> outputs 1,2,...,7; no underrun.
- Write encode: FIFO full, wr_valid with addr 5, pixel 0xA -> one-cycle handshake; next cycle mem_en=1, we=1, addr=1, wmask=0010, wdata=0xAAAA.
- Priority: scan_reset released while wr_valid is held -> FIFO_DEPTH reads (addr 0..3) are issued before wr_ready rises; the write follows.
- Wrap: FRAME_WORDS=4, 16 edges -> read addresses 0,1,2,3,0...; 17th pixel equals word0 nibble 0.
- Underrun/flush: edges every 2 cycles starting 1 cycle after release -> scan_underrun_out=1, stays 1 after a further scan_reset pulse, and clears only on rst. Asserting scan_reset with a read in flight -> that data is discarded; the next pixel is word0 nibble 0.
- FB_CLEAR_EN: clear_req with value 5, FRAME_WORDS=8 -> eight writes of 0x5555, mask 1111, addrs 0..7; clear_busy high throughout; wr_ready=0 during the clear.

Source files
------------

// File: rtl/fb_scan_arbiter_if.sv
// Bus bundle between fb_scan_arbiter (slave) and its environment (master):
// VGA scanout, rasteriser write port and SRAM macro signals.
interface fb_scan_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  scan_next_pixel_in;
  logic                  scan_reset_in;
  logic [3:0]            scan_pixel_out;
  logic                  scan_underrun_out;
  logic                  wr_valid_in;
  logic                  wr_ready_out;
  logic [ADDR_WIDTH+1:0] wr_addr_in;
  logic [3:0]            wr_pixel_in;
  logic                  mem_en_out;
  logic                  mem_we_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [3:0]            mem_wmask_out;
  logic [15:0]           mem_wdata_out;
  logic [15:0]           mem_rdata_in;

  modport slave (
    input  scan_next_pixel_in, scan_reset_in, wr_valid_in, wr_addr_in,
           wr_pixel_in, mem_rdata_in,
    output scan_pixel_out, scan_underrun_out, wr_ready_out, mem_en_out,
           mem_we_out, mem_addr_out, mem_wmask_out, mem_wdata_out
  );

  modport master (
    output scan_next_pixel_in, scan_reset_in, wr_valid_in, wr_addr_in,
           wr_pixel_in, mem_rdata_in,
    input  scan_pixel_out, scan_underrun_out, wr_ready_out, mem_en_out,
           mem_we_out, mem_addr_out, mem_wmask_out, mem_wdata_out
  );
endinterface

// File: rtl/fb_scan_arbiter.sv
// Frame-buffer SRAM arbiter: scanout prefetch FIFO has priority over draw writes.
// Optional frame clear engine enabled by defining FB_CLEAR_EN.
module fb_scan_arbiter #(
  parameter int ADDR_WIDTH  = 14,
  parameter int FRAME_WORDS = 4800,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef FB_CLEAR_EN
  input  logic       clear_req_in,
  input  logic [3:0] clear_value_in,
  output logic       clear_busy_out,
`endif
  fb_scan_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD   = ADDR_WIDTH'(FRAME_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   FRAME_LIMIT = (ADDR_WIDTH+1)'(FRAME_WORDS);
  localparam logic [0:0] RUN = 1'b0;
`ifdef FB_CLEAR_EN
  localparam logic [0:0] CLEAR = 1'b1;
`endif

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [1:0]            nib;
  logic                  next_q;
  logic                  underrun;
  logic [15:0]           fifo [FIFO_DEPTH];
  logic [PW-1:0]         head, tail;
  logic [PW:0]           count;
  // Live reads at the strobe stage and at the data-return stage; a scan
  // reset clears them so returns belonging to the old frame are discarded.
  logic                  issue_q, return_q;

  logic [PW+1:0]         occupancy;
  logic                  rd_grant, wr_accept, rise, pop, push;
  logic [ADDR_WIDTH-1:0] wr_word;
  logic                  wr_in_frame;

`ifdef FB_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [3:0]            clr_val;
  assign clear_busy_out = (state == CLEAR);
`endif

  assign occupancy   = (PW+2)'(count) + (PW+2)'(issue_q) + (PW+2)'(return_q);
  assign rd_grant    = !bus.scan_reset_in && (occupancy < (PW+2)'(FIFO_DEPTH));
  assign bus.wr_ready_out = (state == RUN) && !rst && !rd_grant;
  assign wr_accept   = bus.wr_valid_in && bus.wr_ready_out;
  assign wr_word     = bus.wr_addr_in[ADDR_WIDTH+1:2];
  assign wr_in_frame = {1'b0, wr_word} < FRAME_LIMIT;

  assign rise = bus.scan_next_pixel_in && !next_q && !bus.scan_reset_in;
  assign pop  = rise && (count != '0) && (nib == 2'd3);
  assign push = return_q && !bus.scan_reset_in;

  assign bus.scan_pixel_out    = (count == '0) ? 4'h0 : fifo[head][{nib, 2'b00} +: 4];
  assign bus.scan_underrun_out = underrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_en_out    <= 1'b0;
      bus.mem_we_out    <= 1'b0;
      bus.mem_addr_out  <= '0;
      bus.mem_wmask_out <= '0;
      bus.mem_wdata_out <= '0;
    end else begin
      bus.mem_en_out    <= 1'b0;
      bus.mem_we_out    <= 1'b0;
      bus.mem_addr_out  <= '0;
      bus.mem_wmask_out <= '0;
      bus.mem_wdata_out <= '0;
      if (rd_grant) begin
        bus.mem_en_out   <= 1'b1;
        bus.mem_addr_out <= rd_ptr;
      end
`ifdef FB_CLEAR_EN
      else if (state == CLEAR) begin
        bus.mem_en_out    <= 1'b1;
        bus.mem_we_out    <= 1'b1;
        bus.mem_addr_out  <= clr_ptr;
        bus.mem_wmask_out <= '1;
        bus.mem_wdata_out <= {4{clr_val}};
      end
`endif
      else if (wr_accept && wr_in_frame) begin
        bus.mem_en_out    <= 1'b1;
        bus.mem_we_out    <= 1'b1;
        bus.mem_addr_out  <= wr_word;
        bus.mem_wmask_out <= 4'b0001 << bus.wr_addr_in[1:0];
        bus.mem_wdata_out <= {4{bus.wr_pixel_in}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[tail] <= bus.mem_rdata_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      nib      <= '0;
      next_q   <= 1'b0;
      underrun <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      issue_q  <= 1'b0;
      return_q <= 1'b0;
    end else begin
      next_q   <= bus.scan_next_pixel_in;
      issue_q  <= rd_grant;
      return_q <= issue_q && !bus.scan_reset_in;
      if (bus.scan_reset_in) begin
        rd_ptr <= '0;
        nib    <= '0;
        head   <= '0;
        tail   <= '0;
        count  <= '0;
      end else begin
        if (rd_grant) rd_ptr <= (rd_ptr == LAST_WORD) ? '0 : rd_ptr + ADDR_WIDTH'(1);
        if (rise) begin
          if (count == '0) underrun <= 1'b1;
          else             nib <= nib + 2'd1;
        end
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
`ifdef FB_CLEAR_EN
      clr_ptr <= '0;
      clr_val <= '0;
    end else if (state == RUN) begin
      if (clear_req_in) begin
        state   <= CLEAR;
        clr_val <= clear_value_in;
        clr_ptr <= '0;
      end
    end else if (!rd_grant) begin
      // The sweep only advances in cycles the write slot was actually used.
      clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
      if (clr_ptr == LAST_WORD) state <= RUN;
    end
`else
    end else begin
      state <= RUN;
    end
`endif
  end
endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Scoreboard bench for fb_scan_arbiter with an 8-word frame and behavioural SRAM.
module tb_fb_scan_arbiter;
  localparam int AW = 14;
  localparam int FW = 8;
  localparam int FD = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    mask;
    logic [15:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  always #5 clk = ~clk;

  fb_scan_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef FB_CLEAR_EN
  logic       clear_req;
  logic [3:0] clear_value;
  logic       clear_busy;
`endif

  fb_scan_arbiter #(.ADDR_WIDTH(AW), .FRAME_WORDS(FW), .FIFO_DEPTH(FD)) dut (
    .clk(clk),
    .rst(rst),
`ifdef FB_CLEAR_EN
    .clear_req_in(clear_req),
    .clear_value_in(clear_value),
    .clear_busy_out(clear_busy),
`endif
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_pix [$];
  wr_t        exp_wr  [$];
  logic [AW-1:0] rd_log [$];
  wr_t           wr_log [$];

  // Pixel 4k+i holds (4k+i) mod 16.
  function automatic logic [15:0] pat(int k);
    logic [15:0] w;
    for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'((4*k + i) & 15);
    return w;
  endfunction

  logic [15:0] sram [0:63];
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 64; k++) sram[k] <= pat(k);
    end else if (bus.mem_en_out) begin
      if (bus.mem_we_out) begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_wmask_out[i])
            sram[bus.mem_addr_out[5:0]][4*i +: 4] <= bus.mem_wdata_out[4*i +: 4];
      end else begin
        bus.mem_rdata_in <= sram[bus.mem_addr_out[5:0]];
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_en_out && !bus.mem_we_out) rd_log.push_back(bus.mem_addr_out);
    if (bus.mem_en_out && bus.mem_we_out)
      wr_log.push_back('{addr: bus.mem_addr_out, mask: bus.mem_wmask_out, data: bus.mem_wdata_out});
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic edges(int first, int last, int gap);
    logic [3:0] e;
    for (int p = first; p <= last; p++) begin
      exp_pix.push_back(4'((p % (4*FW)) & 15));
      bus.scan_next_pixel_in = 1'b1;
      tick(1);
      bus.scan_next_pixel_in = 1'b0;
      e = exp_pix.pop_front();
      vectors++;
      if (bus.scan_pixel_out !== e) begin
        miscompares++;
        $display("FAIL pixel_%0d: got %0h want %0h", p, bus.scan_pixel_out, e);
      end
      tick(gap - 1);
    end
  endtask

  task automatic restart_scan(int hold);
    bus.scan_reset_in = 1'b1;
    tick(hold);
    bus.scan_reset_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    preload = 1'b1;
    bus.scan_next_pixel_in = 1'b0;
    bus.scan_reset_in = 1'b1;
    bus.wr_valid_in = 1'b0;
    bus.wr_addr_in = '0;
    bus.wr_pixel_in = '0;
`ifdef FB_CLEAR_EN
    clear_req = 1'b0;
    clear_value = '0;
`endif
    tick(3);
    preload = 1'b0;
    vectors += 8;
    if (bus.scan_pixel_out !== 4'h0) begin miscompares++; $display("FAIL reset_pixel: got %0h want 0", bus.scan_pixel_out); end
    if (bus.scan_underrun_out !== 1'b0) begin miscompares++; $display("FAIL reset_underrun: got %0b want 0", bus.scan_underrun_out); end
    if (bus.wr_ready_out !== 1'b0) begin miscompares++; $display("FAIL reset_wr_ready: got %0b want 0", bus.wr_ready_out); end
    if (bus.mem_en_out !== 1'b0) begin miscompares++; $display("FAIL reset_mem_en: got %0b want 0", bus.mem_en_out); end
    if (bus.mem_we_out !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %0b want 0", bus.mem_we_out); end
    if (bus.mem_addr_out !== '0) begin miscompares++; $display("FAIL reset_mem_addr: got %0h want 0", bus.mem_addr_out); end
    if (bus.mem_wmask_out !== 4'h0) begin miscompares++; $display("FAIL reset_mem_wmask: got %0h want 0", bus.mem_wmask_out); end
    if (bus.mem_wdata_out !== 16'h0) begin miscompares++; $display("FAIL reset_mem_wdata: got %0h want 0", bus.mem_wdata_out); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_prefetch();
    restart_scan(10);
    tick(1);
    vectors++;
    if (bus.mem_en_out !== 1'b1 || bus.mem_we_out !== 1'b0 || bus.mem_addr_out !== '0) begin
      miscompares++;
      $display("FAIL first_read: got en=%0b we=%0b addr=%0h want en=1 we=0 addr=0",
               bus.mem_en_out, bus.mem_we_out, bus.mem_addr_out);
    end
    tick(3);
    edges(1, 7, 4);
    vectors++;
    if (bus.scan_underrun_out !== 1'b0) begin miscompares++; $display("FAIL prefetch_underrun: got %0b want 0", bus.scan_underrun_out); end
  endtask

  task automatic test_write_encode();
    wr_t e;
    tick(6);
    bus.wr_valid_in = 1'b1;
    bus.wr_addr_in = 16'd5;
    bus.wr_pixel_in = 4'hA;
    exp_wr.push_back('{addr: 14'd1, mask: 4'b0010, data: 16'hAAAA});
    #1;
    vectors++;
    if (bus.wr_ready_out !== 1'b1) begin miscompares++; $display("FAIL write_ready: got %0b want 1", bus.wr_ready_out); end
    tick(1);
    bus.wr_valid_in = 1'b0;
    e = exp_wr.pop_front();
    vectors += 2;
    if (bus.mem_en_out !== 1'b1 || bus.mem_we_out !== 1'b1) begin
      miscompares++;
      $display("FAIL write_strobe: got en=%0b we=%0b want en=1 we=1", bus.mem_en_out, bus.mem_we_out);
    end
    if ({bus.mem_addr_out, bus.mem_wmask_out, bus.mem_wdata_out} !== e) begin
      miscompares++;
      $display("FAIL write_encode: got addr=%0h mask=%b data=%0h want addr=%0h mask=%b data=%0h",
               bus.mem_addr_out, bus.mem_wmask_out, bus.mem_wdata_out, e.addr, e.mask, e.data);
    end
    vectors++;
    if (bus.wr_ready_out !== 1'b1) begin miscompares++; $display("FAIL write_ready_after: got %0b want 1", bus.wr_ready_out); end
    // Out-of-frame word: handshake completes, no SRAM strobe.
    bus.wr_valid_in = 1'b1;
    bus.wr_addr_in = 16'(4*FW + 2);
    tick(1);
    bus.wr_valid_in = 1'b0;
    vectors++;
    if (bus.mem_en_out !== 1'b0) begin miscompares++; $display("FAIL write_drop: got en=%0b want 0", bus.mem_en_out); end
    // Put the original nibble back into word 1.
    bus.wr_valid_in = 1'b1;
    bus.wr_addr_in = 16'd5;
    bus.wr_pixel_in = 4'h5;
    tick(1);
    bus.wr_valid_in = 1'b0;
    tick(2);
  endtask

  task automatic test_priority();
    wr_t e;
    restart_scan(3);
    bus.wr_valid_in = 1'b1;
    bus.wr_addr_in = 16'd27;
    bus.wr_pixel_in = 4'hB;
    exp_wr.push_back('{addr: 14'd6, mask: 4'b1000, data: 16'hBBBB});
    for (int i = 0; i < FD; i++) begin
      #1;
      vectors++;
      if (bus.wr_ready_out !== 1'b0) begin miscompares++; $display("FAIL prio_ready_%0d: got %0b want 0", i, bus.wr_ready_out); end
      @(posedge clk);
      #1;
      vectors++;
      if (bus.mem_en_out !== 1'b1 || bus.mem_we_out !== 1'b0 || bus.mem_addr_out !== AW'(i)) begin
        miscompares++;
        $display("FAIL prio_read_%0d: got en=%0b we=%0b addr=%0h want en=1 we=0 addr=%0h",
                 i, bus.mem_en_out, bus.mem_we_out, bus.mem_addr_out, i);
      end
    end
    #1;
    vectors++;
    if (bus.wr_ready_out !== 1'b1) begin miscompares++; $display("FAIL prio_ready_rise: got %0b want 1", bus.wr_ready_out); end
    @(posedge clk);
    #1;
    bus.wr_valid_in = 1'b0;
    e = exp_wr.pop_front();
    vectors++;
    if (bus.mem_en_out !== 1'b1 || bus.mem_we_out !== 1'b1 ||
        {bus.mem_addr_out, bus.mem_wmask_out, bus.mem_wdata_out} !== e) begin
      miscompares++;
      $display("FAIL prio_write: got en=%0b we=%0b addr=%0h mask=%b data=%0h want en=1 we=1 addr=%0h mask=%b data=%0h",
               bus.mem_en_out, bus.mem_we_out, bus.mem_addr_out, bus.mem_wmask_out,
               bus.mem_wdata_out, e.addr, e.mask, e.data);
    end
  endtask

  task automatic test_wrap();
    restart_scan(3);
    rd_log.delete();
    tick(4);
    edges(1, 4*FW + 1, 4);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (rd_log.size() == 0) begin
        miscompares++;
        $display("FAIL wrap_read_%0d: got none want addr %0h", i, i % FW);
      end else if (rd_log[0] !== AW'(i % FW)) begin
        miscompares++;
        $display("FAIL wrap_read_%0d: got %0h want %0h", i, rd_log[0], i % FW);
        void'(rd_log.pop_front());
      end else begin
        void'(rd_log.pop_front());
      end
    end
  endtask

  task automatic test_underrun_flush();
    restart_scan(3);
    tick(1);
    for (int k = 0; k < 4; k++) begin
      bus.scan_next_pixel_in = 1'b1;
      tick(1);
      bus.scan_next_pixel_in = 1'b0;
      tick(1);
    end
    vectors++;
    if (bus.scan_underrun_out !== 1'b1) begin miscompares++; $display("FAIL underrun_set: got %0b want 1", bus.scan_underrun_out); end
    restart_scan(3);
    tick(2);
    vectors++;
    if (bus.scan_underrun_out !== 1'b1) begin miscompares++; $display("FAIL underrun_sticky: got %0b want 1", bus.scan_underrun_out); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    vectors++;
    if (bus.scan_underrun_out !== 1'b0) begin miscompares++; $display("FAIL underrun_clear: got %0b want 0", bus.scan_underrun_out); end
    // One-cycle scan reset while the read of word 0 is in flight.
    restart_scan(3);
    tick(1);
    restart_scan(1);
    tick(4);
    edges(1, 7, 4);
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    wr_t e;
    bus.scan_reset_in = 1'b1;
    tick(3);
    wr_log.delete();
    clear_value = 4'h5;
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    for (int i = 0; i < FW; i++) exp_wr.push_back('{addr: AW'(i), mask: 4'b1111, data: 16'h5555});
    for (int i = 0; i < FW; i++) begin
      vectors++;
      if (clear_busy !== 1'b1 || bus.wr_ready_out !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_busy_%0d: got busy=%0b ready=%0b want busy=1 ready=0", i, clear_busy, bus.wr_ready_out);
      end
      tick(1);
    end
    vectors++;
    if (clear_busy !== 1'b0) begin miscompares++; $display("FAIL clear_done: got %0b want 0", clear_busy); end
    tick(1);
    for (int i = 0; i < FW; i++) begin
      e = exp_wr.pop_front();
      vectors++;
      if (wr_log.size() == 0) begin
        miscompares++;
        $display("FAIL clear_write_%0d: got none want addr=%0h", i, e.addr);
      end else if (wr_log[0] !== e) begin
        miscompares++;
        $display("FAIL clear_write_%0d: got addr=%0h mask=%b data=%0h want addr=%0h mask=%b data=%0h",
                 i, wr_log[0].addr, wr_log[0].mask, wr_log[0].data, e.addr, e.mask, e.data);
        void'(wr_log.pop_front());
      end else begin
        void'(wr_log.pop_front());
      end
    end
    preload = 1'b1;
    tick(1);
    preload = 1'b0;
    bus.scan_reset_in = 1'b0;
    tick(2);
  endtask
`endif

  initial begin
    test_reset();
    test_prefetch();
    test_write_encode();
    test_priority();
    test_wrap();
    test_underrun_flush();
`ifdef FB_CLEAR_EN
    test_clear();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
